// File: rtl/sspi_pkg.sv
// sspi_pkg: opcodes, FSM state encoding and CRC-8 helper shared by the SPI command slave.
// Contents: OP_* opcode bytes, CRC_POLY, state_t, crc8_update().
// Imported by sspi_byte_io and sspi_cmd_slave.
package sspi_pkg;

  localparam logic [7:0] OP_READ_ID  = 8'h01;
  localparam logic [7:0] OP_WR_CFG   = 8'h02;
  localparam logic [7:0] OP_RD_CFG   = 8'h03;
  localparam logic [7:0] OP_STREAM   = 8'h07;
  localparam logic [7:0] OP_READ_CRC = 8'h08;

  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_IDX,
    ST_WDATA,
    ST_TX,
    ST_LEN,
    ST_DATA,
    ST_IGNORE
  } state_t;

  // One byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sspi_byte_io.sv
// sspi_byte_io: oversampled SPI mode-0 byte engine (pin synchronisers, sclk edge detect, RX/TX shifters).
// Latency: rx_strobe_o 1 clk after the 8th detected sclk rise (3-4 clk after the pin edge). No backpressure.
// Ports: raw SPI pins in; cs_active_o framing, rx_byte_o/rx_strobe_o out; tx_load_i/tx_byte_i preload; miso_o.
module sspi_byte_io
  import sspi_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       sspi_cs_i,
  input  logic       sspi_clk_i,
  input  logic       sspi_mosi_i,
  input  logic       tx_load_i,
  input  logic [7:0] tx_byte_i,
  output logic       cs_active_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_strobe_o,
  output logic       miso_o
);

  // Chip select is synchronised in its active-high sense so the reset value
  // (0) means "deselected".
  logic cs_meta_q, cs_sync_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_strobe_q, rx_strobe_d;
  logic [7:0] tx_sh_q, tx_sh_d;

  logic sclk_rise, sclk_fall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      cs_meta_q   <= ~sspi_cs_i;
      cs_sync_q   <= cs_meta_q;
      sclk_meta_q <= sspi_clk_i;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= sspi_mosi_i;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_byte_d   = rx_byte_q;
    rx_strobe_d = 1'b0;
    tx_sh_d     = tx_sh_q;
    if (!cs_sync_q) begin
      // Deselect aborts any partial byte.
      bit_cnt_d = 3'd0;
      tx_sh_d   = 8'h00;
    end else begin
      if (sclk_rise) begin
        rx_sh_d   = {rx_sh_q[5:0], mosi_sync_q};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_d   = {rx_sh_q, mosi_sync_q};
          rx_strobe_d = 1'b1;
        end
      end
      // The fall that ends bit 7 (counter back at 0) must not shift: the
      // MSB of the next byte is preloaded and already on the pin.
      if (tx_load_i) begin
        tx_sh_d = tx_byte_i;
      end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
        tx_sh_d = {tx_sh_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 7'd0;
      rx_byte_q   <= 8'h00;
      rx_strobe_q <= 1'b0;
      tx_sh_q     <= 8'h00;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_byte_q   <= rx_byte_d;
      rx_strobe_q <= rx_strobe_d;
      tx_sh_q     <= tx_sh_d;
    end
  end

  assign cs_active_o = cs_sync_q;
  assign rx_byte_o   = rx_byte_q;
  assign rx_strobe_o = rx_strobe_q;
  // Gate with the raw pin as well so MISO is quiet as soon as cs goes high.
  assign miso_o      = ~sspi_cs_i & cs_sync_q & tx_sh_q[7];

endmodule

// File: rtl/sspi_cmd_slave.sv
// sspi_cmd_slave: SPI-slave command engine - READ_ID, config register write/readback, length-prefixed payload streaming.
// Latency: cfg_wr/stream strobes 1 clk after the byte strobe (<= 4 clk after the last sclk rise). No backpressure.
// Ports: SPI pins, cfg bank (flattened) + cfg_wr, stream_active/data/valid/done. Optional macro SSPI_CRC_EN adds CRC-8 readback.
module sspi_cmd_slave
  import sspi_pkg::*;
#(
  parameter logic [7:0] CORE_ID   = 8'h01,
  parameter int         CFG_WORDS = 4,
  parameter int         CFG_W     = 32,
  parameter int         LEN_BYTES = 3
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       sspi_cs,
  input  logic                       sspi_clk,
  input  logic                       sspi_mosi,
  output logic                       sspi_miso,
  output logic [CFG_WORDS*CFG_W-1:0] cfg,
  output logic [CFG_WORDS-1:0]       cfg_wr,
  output logic                       stream_active,
  output logic [7:0]                 stream_data,
  output logic                       stream_valid,
  output logic                       stream_done
);

  localparam int CFG_BYTES = CFG_W / 8;
  localparam int LEN_W     = 8 * LEN_BYTES;

  logic       cs_active;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       tx_load;
  logic [7:0] tx_byte;

  sspi_byte_io u_byte_io (
    .clk         (clk),
    .resetn      (resetn),
    .sspi_cs_i   (sspi_cs),
    .sspi_clk_i  (sspi_clk),
    .sspi_mosi_i (sspi_mosi),
    .tx_load_i   (tx_load),
    .tx_byte_i   (tx_byte),
    .cs_active_o (cs_active),
    .rx_byte_o   (rx_byte),
    .rx_strobe_o (rx_strobe),
    .miso_o      (sspi_miso)
  );

  state_t               state_q, state_d;
  logic                 is_wr_q, is_wr_d;
  logic [7:0]           idx_q, idx_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [CFG_W-1:0]     shadow_q, shadow_d;
  logic [CFG_W-1:0]     tx_word_q, tx_word_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [CFG_W-1:0]     cfg_q [CFG_WORDS];
  logic [CFG_W-1:0]     cfg_d [CFG_WORDS];
  logic [CFG_WORDS-1:0] cfg_wr_q, cfg_wr_d;
  logic                 stream_active_q, stream_active_d;
  logic [7:0]           stream_data_q, stream_data_d;
  logic                 stream_valid_q, stream_valid_d;
  logic                 stream_done_q, stream_done_d;
`ifdef SSPI_CRC_EN
  logic [7:0]           crc_q, crc_d;
`endif

  logic [CFG_W-1:0] sel_word;
  logic [CFG_W-1:0] shadow_next;
  logic [LEN_W-1:0] len_next;

  // Readback word addressed by the byte just received; out-of-range reads 0.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < CFG_WORDS; i++) begin
      if (rx_byte == 8'(i)) sel_word = cfg_q[i];
    end
  end

  assign shadow_next = (shadow_q << 8) | CFG_W'(rx_byte);
  assign len_next    = (len_q << 8) | LEN_W'(rx_byte);

  always_comb begin
    state_d         = state_q;
    is_wr_d         = is_wr_q;
    idx_d           = idx_q;
    bcnt_d          = bcnt_q;
    shadow_d        = shadow_q;
    tx_word_d       = tx_word_q;
    len_d           = len_q;
    cfg_d           = cfg_q;
    cfg_wr_d        = '0;
    stream_active_d = stream_active_q;
    stream_data_d   = stream_data_q;
    stream_valid_d  = 1'b0;
    stream_done_d   = 1'b0;
    tx_load         = 1'b0;
    tx_byte         = 8'h00;
`ifdef SSPI_CRC_EN
    crc_d           = crc_q;
`endif

    // stream_active falls one cycle after the done strobe.
    if (stream_done_q) stream_active_d = 1'b0;

    if (!cs_active) begin
      state_d         = ST_IDLE;
      stream_active_d = 1'b0;
    end else begin
      // Every byte boundary reloads the TX shifter; it carries 0x00 unless
      // the state below supplies read data.
      tx_load = rx_strobe;
      unique case (state_q)
        ST_IDLE: state_d = ST_CMD;

        ST_CMD: if (rx_strobe) begin
          bcnt_d = 4'd0;
          case (rx_byte)
            OP_READ_ID: begin
              tx_byte   = CORE_ID;
              tx_word_d = '0;
              state_d   = ST_TX;
            end
            OP_WR_CFG: begin
              is_wr_d = 1'b1;
              state_d = ST_IDX;
            end
            OP_RD_CFG: begin
              is_wr_d = 1'b0;
              state_d = ST_IDX;
            end
            OP_STREAM: begin
              len_d   = '0;
`ifdef SSPI_CRC_EN
              crc_d   = 8'h00;
`endif
              state_d = ST_LEN;
            end
            OP_READ_CRC: begin
`ifdef SSPI_CRC_EN
              tx_byte = crc_q;
`else
              tx_byte = 8'h00;
`endif
              tx_word_d = '0;
              state_d   = ST_TX;
            end
            default: state_d = ST_IGNORE;
          endcase
        end

        ST_IDX: if (rx_strobe) begin
          idx_d    = rx_byte;
          shadow_d = '0;
          if (is_wr_q) begin
            state_d = ST_WDATA;
          end else begin
            tx_byte   = sel_word[CFG_W-1 -: 8];
            tx_word_d = sel_word << 8;
            state_d   = ST_TX;
          end
        end

        ST_WDATA: if (rx_strobe) begin
          shadow_d = shadow_next;
          bcnt_d   = bcnt_q + 4'd1;
          if (bcnt_q == 4'(CFG_BYTES - 1)) begin
            // Out-of-range index matches no word: data consumed, no write.
            for (int i = 0; i < CFG_WORDS; i++) begin
              if (idx_q == 8'(i)) begin
                cfg_d[i]    = shadow_next;
                cfg_wr_d[i] = 1'b1;
              end
            end
            state_d = ST_IGNORE;
          end
        end

        ST_TX: if (rx_strobe) begin
          tx_byte   = tx_word_q[CFG_W-1 -: 8];
          tx_word_d = tx_word_q << 8;
        end

        ST_LEN: if (rx_strobe) begin
          len_d  = len_next;
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'(LEN_BYTES - 1)) begin
            if (len_next == '0) begin
              stream_done_d = 1'b1;
              state_d       = ST_IGNORE;
            end else begin
              stream_active_d = 1'b1;
              state_d         = ST_DATA;
            end
          end
        end

        ST_DATA: if (rx_strobe) begin
          stream_data_d  = rx_byte;
          stream_valid_d = 1'b1;
          len_d          = len_q - LEN_W'(1);
`ifdef SSPI_CRC_EN
          crc_d          = crc8_update(crc_q, rx_byte);
`endif
          if (len_q == LEN_W'(1)) begin
            stream_done_d = 1'b1;
            state_d       = ST_IGNORE;
          end
        end

        ST_IGNORE: ;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      is_wr_q         <= 1'b0;
      idx_q           <= 8'h00;
      bcnt_q          <= 4'd0;
      shadow_q        <= '0;
      tx_word_q       <= '0;
      len_q           <= '0;
      cfg_q           <= '{default: '0};
      cfg_wr_q        <= '0;
      stream_active_q <= 1'b0;
      stream_data_q   <= 8'h00;
      stream_valid_q  <= 1'b0;
      stream_done_q   <= 1'b0;
`ifdef SSPI_CRC_EN
      crc_q           <= 8'h00;
`endif
    end else begin
      state_q         <= state_d;
      is_wr_q         <= is_wr_d;
      idx_q           <= idx_d;
      bcnt_q          <= bcnt_d;
      shadow_q        <= shadow_d;
      tx_word_q       <= tx_word_d;
      len_q           <= len_d;
      cfg_q           <= cfg_d;
      cfg_wr_q        <= cfg_wr_d;
      stream_active_q <= stream_active_d;
      stream_data_q   <= stream_data_d;
      stream_valid_q  <= stream_valid_d;
      stream_done_q   <= stream_done_d;
`ifdef SSPI_CRC_EN
      crc_q           <= crc_d;
`endif
    end
  end

  for (genvar g = 0; g < CFG_WORDS; g++) begin : g_cfg
    assign cfg[g*CFG_W +: CFG_W] = cfg_q[g];
  end

  assign cfg_wr        = cfg_wr_q;
  assign stream_active = stream_active_q;
  assign stream_data   = stream_data_q;
  assign stream_valid  = stream_valid_q;
  assign stream_done   = stream_done_q;

endmodule

// File: tb/tb_sspi_cmd_slave.sv
// tb_sspi_cmd_slave: directed SPI-master stimulus with scoreboard queues for MISO bytes, stream strobes and cfg writes.
// Clock 100 MHz, sclk 12 clk per bit (well above the 4x oversampling floor).
// Monitors pop expectations whenever the DUT presents an output event.
module tb_sspi_cmd_slave;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         sspi_cs = 1'b1;
  logic         sspi_clk = 1'b0;
  logic         sspi_mosi = 1'b0;
  logic         sspi_miso;
  logic [127:0] cfg;
  logic [3:0]   cfg_wr;
  logic         stream_active;
  logic [7:0]   stream_data;
  logic         stream_valid;
  logic         stream_done;

  sspi_cmd_slave dut (
    .clk           (clk),
    .resetn        (resetn),
    .sspi_cs       (sspi_cs),
    .sspi_clk      (sspi_clk),
    .sspi_mosi     (sspi_mosi),
    .sspi_miso     (sspi_miso),
    .cfg           (cfg),
    .cfg_wr        (cfg_wr),
    .stream_active (stream_active),
    .stream_data   (stream_data),
    .stream_valid  (stream_valid),
    .stream_done   (stream_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic valid; logic [7:0] data; logic done; } strm_t;
  typedef struct { int idx; logic [3:0] mask; logic [31:0] word; } wr_t;

  strm_t      exp_strm[$];
  wr_t        exp_wr[$];
  logic [7:0] exp_miso[$];

  logic [7:0] miso_obs;
  event       miso_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitors ----------------
  strm_t se;
  wr_t   we;
  logic  prev_done = 1'b0;

  always @(negedge clk) begin
    if (resetn) begin
      if (prev_done) check("active_after_done", stream_active, 1'b0);
      if (stream_valid || stream_done) begin
        if (exp_strm.size() == 0) begin
          check("strm_unexpected", {stream_valid, stream_done}, 2'b00);
        end else begin
          se = exp_strm.pop_front();
          check("strm_valid", stream_valid, se.valid);
          check("strm_done", stream_done, se.done);
          check("strm_active", stream_active, se.valid);
          if (se.valid) check("strm_data", stream_data, se.data);
        end
      end
      if (cfg_wr != 4'b0000) begin
        if (exp_wr.size() == 0) begin
          check("cfg_wr_unexpected", cfg_wr, 4'b0000);
        end else begin
          we = exp_wr.pop_front();
          check("cfg_wr_mask", cfg_wr, we.mask);
          check("cfg_wr_word", cfg[we.idx*32 +: 32], we.word);
        end
      end
      prev_done = stream_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  always @(miso_ev) begin
    if (exp_miso.size() == 0) check("miso_unexpected", miso_obs, 8'hxx);
    else check("miso_byte", miso_obs, exp_miso.pop_front());
  end

  // ---------------- SPI master ----------------
  task automatic spi_byte(input logic [7:0] mosi_b, input logic [7:0] miso_exp);
    logic [7:0] r;
    exp_miso.push_back(miso_exp);
    for (int b = 7; b >= 0; b--) begin
      sspi_mosi = mosi_b[b];
      #60;
      r[b] = sspi_miso;
      sspi_clk = 1'b1;
      #60;
      sspi_clk = 1'b0;
    end
    miso_obs = r;
    -> miso_ev;
  endtask

  task automatic cs_lo();
    sspi_cs = 1'b0;
    #100;
  endtask

  task automatic cs_hi();
    #100;
    sspi_cs = 1'b1;
    #200;
  endtask

  task automatic push_strm(input logic v, input logic [7:0] d, input logic dn);
    strm_t s;
    s.valid = v; s.data = d; s.done = dn;
    exp_strm.push_back(s);
  endtask

  task automatic read_id();
    cs_lo();
    spi_byte(8'h01, 8'h00);
    spi_byte(8'h00, 8'h01);
    spi_byte(8'h00, 8'h00);
    cs_hi();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_miso"}, sspi_miso, 1'b0);
    check({tag, "_cfg_zero"}, (cfg == 128'd0), 1'b1);
    check({tag, "_cfg_wr"}, cfg_wr, 4'b0000);
    check({tag, "_active"}, stream_active, 1'b0);
    check({tag, "_data"}, stream_data, 8'h00);
    check({tag, "_valid"}, stream_valid, 1'b0);
    check({tag, "_done"}, stream_done, 1'b0);
  endtask

`ifdef SSPI_CRC_EN
  function automatic logic [7:0] tb_crc(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    wr_t w;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // 1. READ_ID
    read_id();

    // 2. WR_CFG word 1
    w.idx = 1; w.mask = 4'b0010; w.word = 32'hA5A5_5A5A;
    exp_wr.push_back(w);
    cs_lo();
    spi_byte(8'h02, 8'h00);
    spi_byte(8'h01, 8'h00);
    spi_byte(8'hA5, 8'h00);
    spi_byte(8'hA5, 8'h00);
    spi_byte(8'h5A, 8'h00);
    spi_byte(8'h5A, 8'h00);
    cs_hi();
    check("wr_cfg0", cfg[31:0], 32'h0);
    check("wr_cfg1", cfg[63:32], 32'hA5A5_5A5A);
    check("wr_cfg2", cfg[95:64], 32'h0);
    check("wr_cfg3", cfg[127:96], 32'h0);

    // 3. RD_CFG word 1, one extra byte, then out-of-range index
    cs_lo();
    spi_byte(8'h03, 8'h00);
    spi_byte(8'h01, 8'h00);
    spi_byte(8'h00, 8'hA5);
    spi_byte(8'h00, 8'hA5);
    spi_byte(8'h00, 8'h5A);
    spi_byte(8'h00, 8'h5A);
    spi_byte(8'h00, 8'h00);
    cs_hi();
    cs_lo();
    spi_byte(8'h03, 8'h00);
    spi_byte(8'h09, 8'h00);
    for (int i = 0; i < 4; i++) spi_byte(8'h00, 8'h00);
    cs_hi();

    // 4. STREAM of 3 bytes
    cs_lo();
    spi_byte(8'h07, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    #20;
    check("stream_active_before_len", stream_active, 1'b0);
    spi_byte(8'h03, 8'h00);
    #20;
    check("stream_active_after_len", stream_active, 1'b1);
    push_strm(1'b1, 8'h11, 1'b0);
    push_strm(1'b1, 8'h22, 1'b0);
    push_strm(1'b1, 8'h33, 1'b1);
    spi_byte(8'h11, 8'h00);
    spi_byte(8'h22, 8'h00);
    spi_byte(8'h33, 8'h00);
    #100;
    check("stream_active_end", stream_active, 1'b0);
    cs_hi();

    // CRC readback (0x00 when the CRC option is absent)
    cs_lo();
    spi_byte(8'h08, 8'h00);
`ifdef SSPI_CRC_EN
    spi_byte(8'h00, tb_crc(tb_crc(tb_crc(8'h00, 8'h11), 8'h22), 8'h33));
`else
    spi_byte(8'h00, 8'h00);
`endif
    cs_hi();

    // 5a. STREAM length 5, aborted after 2 bytes
    cs_lo();
    spi_byte(8'h07, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h05, 8'h00);
    push_strm(1'b1, 8'h01, 1'b0);
    push_strm(1'b1, 8'h02, 1'b0);
    spi_byte(8'h01, 8'h00);
    spi_byte(8'h02, 8'h00);
    #20;
    check("abort_active_before", stream_active, 1'b1);
    sspi_cs = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_active_after", stream_active, 1'b0);
    #200;

    // 5b. STREAM length 0
    push_strm(1'b0, 8'h00, 1'b1);
    cs_lo();
    spi_byte(8'h07, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    #20;
    check("len0_active", stream_active, 1'b0);
    cs_hi();

    // 5c. WR_CFG word 2 cut after 3 data bytes
    cs_lo();
    spi_byte(8'h02, 8'h00);
    spi_byte(8'h02, 8'h00);
    spi_byte(8'h11, 8'h00);
    spi_byte(8'h22, 8'h00);
    spi_byte(8'h33, 8'h00);
    cs_hi();
    check("cut_cfg2", cfg[95:64], 32'h0);
    check("cut_cfg1", cfg[63:32], 32'hA5A5_5A5A);

    // 6. Reset in the middle of DATA
    cs_lo();
    spi_byte(8'h07, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h00, 8'h00);
    spi_byte(8'h04, 8'h00);
    push_strm(1'b1, 8'hAA, 1'b0);
    spi_byte(8'hAA, 8'h00);
    #20;
    check("pre_reset_active", stream_active, 1'b1);
    sspi_mosi = 1'b1;
    #60;
    sspi_clk = 1'b1;
    #30;
    resetn = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    #29;
    sspi_clk = 1'b0;
    sspi_cs  = 1'b1;
    #50;
    resetn = 1'b1;
    #200;
    check("post_reset_cfg_zero", (cfg == 128'd0), 1'b1);
    read_id();

    #200;
    check("strm_queue_drained", exp_strm.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("miso_queue_drained", exp_miso.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
